// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 24-bit instruction words over a req/ack memory
// handshake, tracks the PC, and hands each word to decode over valid/ready.
// Branch redirects flush the in-flight fetch and restart at the new target.
// Optional build macro IFU_STALL_CNT_EN adds a saturating consumer-stall counter.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [23:0]       imem_rdata,
  output logic [23:0]       code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [ADDR_W-1:0] code_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_code;
  logic [ADDR_W-1:0] r_codePc;
  logic              r_codeValid;

  state_t            w_stateNext;
  logic [ADDR_W-1:0] w_pcNext;
  logic              w_capture;
  logic              w_dropValid;

  // Next-state and PC selection; a redirect overrides every other event
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_capture   = 1'b0;
    w_dropValid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stateNext = REQ;
        if (redirect_valid) w_pcNext = redirect_pc;
      end
      REQ: begin
        if (redirect_valid) begin
          w_pcNext    = redirect_pc;
          w_stateNext = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          w_capture   = 1'b1;
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_pcNext    = redirect_pc;
          w_dropValid = 1'b1;
          w_stateNext = REQ;
        end else if (r_codeValid && code_ready) begin
          w_pcNext    = r_pc + PC_ONE;
          w_dropValid = 1'b1;
          w_stateNext = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) w_pcNext = redirect_pc;
        if (imem_ack) w_stateNext = REQ;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State, PC and fetch address; the address only moves when a new request
  // starts, so it stays on the abandoned fetch while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_stateNext == REQ) r_addr <= w_pcNext;
    end
  end

  // Output word register: captured on a non-discarded ack, held until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code      <= '0;
      r_codePc    <= '0;
      r_codeValid <= 1'b0;
    end else if (w_capture) begin
      r_code      <= imem_rdata;
      r_codePc    <= r_pc;
      r_codeValid <= 1'b1;
    end else if (w_dropValid) begin
      r_codeValid <= 1'b0;
    end
  end

`ifdef IFU_STALL_CNT_EN
  logic [15:0] r_stallCnt;

  // Count cycles where a word waits on the consumer, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (r_codeValid && !code_ready && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`endif

  assign imem_req   = (r_state == REQ) || (r_state == DRAIN);
  assign imem_addr  = r_addr;
  assign code       = r_code;
  assign code_valid = r_codeValid;
  assign code_pc    = r_codePc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a small instruction memory
// model whose ack latency can be stretched for one chosen address.
// Define IFU_STALL_CNT_EN to also check the stall counter.
module tb_instr_fetch_unit;

  logic        clock;
  logic        resetN;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [23:0] imemRdata;
  logic [23:0] code;
  logic        codeValid;
  logic        codeReady;
  logic [15:0] codePc;
  logic        redirectValid;
  logic [15:0] redirectPc;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  logic [15:0] delayAddr;
  int          delayN;
  int          reqCycles;
  int          vectorCount;
  int          missCount;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clock),
    .rst_n          (resetN),
    .imem_req       (imemReq),
    .imem_addr      (imemAddr),
    .imem_ack       (imemAck),
    .imem_rdata     (imemRdata),
    .code           (code),
    .code_valid     (codeValid),
    .code_ready     (codeReady),
    .code_pc        (codePc),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc)
`ifdef IFU_STALL_CNT_EN
    ,
    .stall_cnt      (stallCnt)
`endif
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  // Memory contents: a few fixed words, everything else is A5 over the address
  function automatic logic [23:0] memRead(input logic [15:0] a);
    case (a)
      16'h0000: memRead = 24'h000130;
      16'h0001: memRead = 24'h400000;
      16'h0002: memRead = 24'h800001;
      16'h0003: memRead = 24'hC00003;
      16'h0040: memRead = 24'h123456;
      default:  memRead = {8'hA5, a};
    endcase
  endfunction

  assign imemRdata = memRead(imemAddr);
  assign imemAck   = imemReq && (reqCycles >= ((imemAddr == delayAddr) ? delayN : 0));

  // Count how long the current request has been waiting for its ack
  always @(posedge clock or negedge resetN) begin
    if (!resetN) reqCycles <= 0;
    else if (imemReq && !imemAck) reqCycles <= reqCycles + 1;
    else reqCycles <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir,
                               input logic [15:0] target);
    codeReady     = ready;
    redirectValid = redir;
    redirectPc    = target;
  endtask

  task automatic expectReq(input string tag, input logic [15:0] addr);
    checkOutput({tag, ".req"}, 32'(imemReq), 32'd1);
    checkOutput({tag, ".addr"}, 32'(imemAddr), 32'(addr));
    checkOutput({tag, ".valid"}, 32'(codeValid), 32'd0);
  endtask

  task automatic expectCode(input string tag, input logic [23:0] word,
                            input logic [15:0] pc);
    checkOutput({tag, ".valid"}, 32'(codeValid), 32'd1);
    checkOutput({tag, ".code"}, 32'(code), 32'(word));
    checkOutput({tag, ".pc"}, 32'(codePc), 32'(pc));
    checkOutput({tag, ".req"}, 32'(imemReq), 32'd0);
  endtask

  task automatic expectResetState(input string tag);
    checkOutput({tag, ".req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, ".addr"}, 32'(imemAddr), 32'd0);
    checkOutput({tag, ".code"}, 32'(code), 32'd0);
    checkOutput({tag, ".valid"}, 32'(codeValid), 32'd0);
    checkOutput({tag, ".pc"}, 32'(codePc), 32'd0);
  endtask

  initial begin
    clock       = 1'b0;
    resetN      = 1'b0;
    vectorCount = 0;
    missCount   = 0;
    delayAddr   = 16'hBEEF;
    delayN      = 0;
    applyStimulus(1'b1, 1'b0, 16'h0000);

    // Reset state, then zero-wait streaming of three words
    @(negedge clock);
    expectResetState("rst");
`ifdef IFU_STALL_CNT_EN
    checkOutput("rst.stall", 32'(stallCnt), 32'd0);
`endif
    @(negedge clock) resetN = 1'b1;
    @(negedge clock) expectReq("s0", 16'h0000);
    @(negedge clock) expectCode("s0", 24'h000130, 16'h0000);
    @(negedge clock) expectReq("s1", 16'h0001);
    @(negedge clock) expectCode("s1", 24'h400000, 16'h0001);
    @(negedge clock) expectReq("s2", 16'h0002);
    @(negedge clock) expectCode("s2", 24'h800001, 16'h0002);

    // Restart with a three-cycle ack delay on address 1
    resetN    = 1'b0;
    delayAddr = 16'h0001;
    delayN    = 3;
    @(negedge clock) resetN = 1'b1;
    @(negedge clock) expectReq("d0", 16'h0000);
    @(negedge clock) expectCode("d0", 24'h000130, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock) expectReq("dwait", 16'h0001);
    end
    @(negedge clock) expectCode("d1", 24'h400000, 16'h0001);

    // Consumer stalls for five cycles; the word must hold
    applyStimulus(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock) expectCode("stall", 24'h400000, 16'h0001);
    end
`ifdef IFU_STALL_CNT_EN
    checkOutput("stall.cnt", 32'(stallCnt), 32'd5);
`endif
    applyStimulus(1'b1, 1'b0, 16'h0000);
    delayAddr = 16'h0003;
    @(negedge clock) expectReq("r2", 16'h0002);
    @(negedge clock) expectCode("r2", 24'h800001, 16'h0002);

    // Redirect while the fetch at 3 waits; it must drain and be discarded
    @(negedge clock) expectReq("r3", 16'h0003);
    applyStimulus(1'b1, 1'b1, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 16'h0000);
      expectReq("drain", 16'h0003);
    end
    @(negedge clock) expectReq("tgt", 16'h0040);
    @(negedge clock) expectCode("tgt", 24'h123456, 16'h0040);
`ifdef IFU_STALL_CNT_EN
    checkOutput("redir.cnt", 32'(stallCnt), 32'd5);
`endif

    // Redirect concurrent with a transfer in HOLD: refetch target, not pc+1
    delayAddr = 16'h0041;
    applyStimulus(1'b1, 1'b1, 16'h0040);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    expectReq("hredir", 16'h0040);
    @(negedge clock) expectCode("hredir", 24'h123456, 16'h0040);
    @(negedge clock) expectReq("inc", 16'h0041);

    // Asynchronous reset in the middle of a pending request
    #2 resetN = 1'b0;
    #1 expectResetState("midrst");
`ifdef IFU_STALL_CNT_EN
    checkOutput("midrst.stall", 32'(stallCnt), 32'd0);
`endif
    delayAddr = 16'hBEEF;
    @(negedge clock) resetN = 1'b1;
    @(negedge clock) expectReq("rs0", 16'h0000);
    @(negedge clock) expectCode("rs0", 24'h000130, 16'h0000);

    // PC wraps from 0xFFFF to 0x0000
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    expectReq("wtop", 16'hFFFF);
    @(negedge clock) expectCode("wtop", 24'hA5FFFF, 16'hFFFF);
    @(negedge clock) expectReq("wrap", 16'h0000);
    @(negedge clock) expectCode("wrap", 24'h000130, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
